// File: rtl/io_pkg.sv
// rtl/io_pkg.sv - shared defaults, interrupt FSM encoding and status bit indices
package io_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    SERVICE = 2'd2
  } int_state_t;

  localparam int ST_TX_OVERRUN  = 0;
  localparam int ST_RX_UNDERRUN = 1;
  localparam int ST_RX_OVERFLOW = 2;

endpackage

// File: rtl/io_port_ctrl_if.sv
// rtl/io_port_ctrl_if.sv - CPU and device side signals of io_port_ctrl
// Ports: none; the signal bundle is split into a slave modport (the controller)
// and a master modport (the CPU/device side driving it).
interface io_port_ctrl_if
  import io_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int PTR_W = $clog2(DEPTH_DEF)
);

  logic [WIDTH-1:0] cpu_data_out;
  logic             cpu_wr;
  logic             cpu_rd;
  logic [WIDTH-1:0] cpu_data_in;
  logic             interrupt;
  logic             int_ack;
  logic [WIDTH-1:0] dev_rx_data;
  logic             dev_rx_valid;
  logic             dev_rx_ready;
  logic [WIDTH-1:0] dev_tx_data;
  logic             dev_tx_valid;
  logic             dev_tx_ready;
  logic [PTR_W:0]   rx_count;
  logic [2:0]       status;

  modport slave (
    input  cpu_data_out, cpu_wr, cpu_rd, int_ack,
    input  dev_rx_data, dev_rx_valid, dev_tx_ready,
    output cpu_data_in, interrupt, dev_rx_ready,
    output dev_tx_data, dev_tx_valid, rx_count, status
  );

  modport master (
    output cpu_data_out, cpu_wr, cpu_rd, int_ack,
    output dev_rx_data, dev_rx_valid, dev_tx_ready,
    input  cpu_data_in, interrupt, dev_rx_ready,
    input  dev_tx_data, dev_tx_valid, rx_count, status
  );

endinterface

// File: rtl/io_fifo.sv
// rtl/io_fifo.sv - synchronous FIFO with count-derived full/empty
// Ports: clk, reset (async high); push/din write the tail; pop advances the
// head; head is the combinational oldest entry; count, full, empty report
// occupancy. Push while full and pop while empty are ignored.
module io_fifo
  import io_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointers are exactly log2(DEPTH) wide, so increment wraps modulo DEPTH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: stale entries are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/io_port_ctrl.sv
// rtl/io_port_ctrl.sv - CPU I/O port: RX/TX byte FIFOs, interrupt FSM, status
// Ports: clk, reset (async high); bus (slave modport) carries the CPU side
// (cpu_data_out/cpu_wr/cpu_rd/cpu_data_in/interrupt/int_ack), the device side
// (dev_rx_*/dev_tx_* valid/ready streams), rx_count and sticky status flags.
module io_port_ctrl
  import io_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           reset,
  io_port_ctrl_if.slave  bus
);

  logic [WIDTH-1:0] rx_head;
  logic [PTR_W:0]   rx_cnt;
  logic             rx_full;
  logic             rx_empty;
  logic             rx_pop;
  logic [PTR_W:0]   tx_cnt;
  logic             tx_full;
  logic             tx_empty;
  logic             unused_tx_cnt;
  int_state_t       state;

  // A pop frees a slot only after the edge, so a full FIFO never accepts a
  // same-cycle push; likewise a device pop never rescues a CPU write to full TX.
  assign bus.dev_rx_ready = !rx_full;
  assign bus.dev_tx_valid = !tx_empty;
  assign bus.rx_count     = rx_cnt;
  assign rx_pop           = bus.cpu_rd && !rx_empty;
  assign unused_tx_cnt    = ^tx_cnt;

  io_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (bus.dev_rx_valid),
    .pop   (rx_pop),
    .din   (bus.dev_rx_data),
    .head  (rx_head),
    .count (rx_cnt),
    .full  (rx_full),
    .empty (rx_empty)
  );

  io_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (bus.cpu_wr),
    .pop   (bus.dev_tx_ready),
    .din   (bus.cpu_data_out),
    .head  (bus.dev_tx_data),
    .count (tx_cnt),
    .full  (tx_full),
    .empty (tx_empty)
  );

  // Read data and sticky error flags. A read of an empty FIFO never bypasses a
  // byte being pushed on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.cpu_data_in <= '0;
      bus.status      <= 3'b000;
    end else begin
      if (rx_pop) bus.cpu_data_in <= rx_head;
      if (bus.cpu_wr && tx_full)        bus.status[ST_TX_OVERRUN]  <= 1'b1;
      if (bus.cpu_rd && rx_empty)       bus.status[ST_RX_UNDERRUN] <= 1'b1;
      if (bus.dev_rx_valid && rx_full)  bus.status[ST_RX_OVERFLOW] <= 1'b1;
    end
  end

  // Interrupt FSM: SERVICE suppresses re-assertion until RX drains completely.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      bus.interrupt <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rx_cnt != '0) begin
            state         <= ASSERT;
            bus.interrupt <= 1'b1;
          end
        end
        ASSERT: begin
          if (bus.int_ack) begin
            state         <= SERVICE;
            bus.interrupt <= 1'b0;
          end
        end
        SERVICE: begin
          if (rx_cnt == '0) state <= IDLE;
        end
        default: begin
          state         <= IDLE;
          bus.interrupt <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/io_port_ctrl.md
Name: io_port_ctrl

Overview:
- I/O peripheral on the far side of the 8-bit processor's data_in / data_out / interrupt interface.
- Buffers bytes arriving from an external device in an RX FIFO, presents them to the CPU on data_in, and raises interrupt while RX data is waiting.
- Accepts bytes the CPU writes on data_out into a TX FIFO and drains them to the device with a valid/ready handshake.

Parameters:
- WIDTH, 8, data byte width (must match the CPU's data_in / data_out).
- DEPTH, 4, entries per FIFO (power of two, ≥2).
- PTR_W, 2, log2(DEPTH).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- cpu_data_out  in  WIDTH  byte from the CPU's data_out.
- cpu_wr  in  1  one-cycle strobe; push cpu_data_out into the TX FIFO.
- cpu_rd  in  1  one-cycle strobe; pop the RX FIFO onto cpu_data_in.
- cpu_data_in  out  WIDTH  registered byte driven to the CPU's data_in.
- interrupt  out  1  registered request to the CPU.
- int_ack  in  1  CPU acknowledge of the interrupt.
- dev_rx_data  in  WIDTH  byte from the device.
- dev_rx_valid  in  1  device offers dev_rx_data.
- dev_rx_ready  out  1  equals !rx_full.
- dev_tx_data  out  WIDTH  TX FIFO head.
- dev_tx_valid  out  1  equals !tx_empty.
- dev_tx_ready  in  1  device accepts dev_tx_data.
- rx_count  out  PTR_W+1  RX occupancy, 0..DEPTH.
- status  out  3  sticky flags: bit0 tx_overrun, bit1 rx_underrun, bit2 rx_overflow_attempt.

Behaviour:
- Reset values (asynchronous, held while reset=1):
  - All pointers and counts = 0.
  - cpu_data_in = 8'h00, interrupt = 0, status = 3'b000.
  - FSM = IDLE.
  - dev_rx_ready = 1, dev_tx_valid = 0.
- RX push: when dev_rx_valid && dev_rx_ready, dev_rx_data is written at the tail and rx_count increments.
- RX pop: when cpu_rd and RX is not empty, cpu_data_in <= head on that edge (visible one cycle after the strobe) and rx_count decrements.
- cpu_rd with RX empty:
  - cpu_data_in holds its previous value.
  - status[1] is set.
  - This includes the case where a push occurs in the same cycle; that pushed byte is not bypassed.
- Simultaneous push and pop with RX not empty: both are performed; rx_count is unchanged.
- RX full: dev_rx_ready = 0, so no push occurs. If dev_rx_valid=1 while full, status[2] is set. A pop in the same cycle does not allow a push; ready re-opens the next cycle.
- TX push: cpu_wr with TX not full pushes cpu_data_out.
- cpu_wr with TX full: the write is dropped and status[0] is set. A same-cycle device pop does not rescue it.
- TX pop: dev_tx_valid && dev_tx_ready advances the head.
- dev_tx_data is the combinational head of the TX FIFO. It is stable while valid && !ready.
- Pointers wrap modulo DEPTH. Full/empty are derived from the count, not from pointer equality.
- Status bits are sticky until reset.
- Interrupt FSM (registered output; interrupt=1 only in ASSERT):
  - IDLE: rx_count≠0 → ASSERT.
  - ASSERT: int_ack → SERVICE (interrupt falls on the same edge). Otherwise stay.
  - SERVICE: rx_count==0 → IDLE. Otherwise stay, with no re-assert until the FIFO has drained once.
  - int_ack in IDLE or SERVICE is ignored.
  - If int_ack arrives on the same edge that the last byte is popped: ASSERT → SERVICE, then SERVICE → IDLE on the next edge.
- Latencies:
  - Device byte to interrupt high: 2 edges (push edge, then FSM edge).
  - cpu_rd to cpu_data_in valid: 1 edge.
- Reset mid-transfer: all FIFO contents are discarded, and the outputs return to their reset values immediately.

Decomposition:
- Shared package io_pkg holds:
  - WIDTH / DEPTH defaults.
  - FSM state encoding: IDLE=2'd0, ASSERT=2'd1, SERVICE=2'd2.
  - Status bit indices.
- One sub-module, io_fifo (WIDTH, DEPTH; push/pop/head/count/full/empty), instantiated twice, for RX and TX.
- The top level contains only the FSM, the cpu_data_in register and the status logic.

Test Plan:
- Reset:
  - Assert reset mid-cycle with 3 bytes queued.
  - Required: interrupt=0, rx_count=0, dev_tx_valid=0, cpu_data_in=8'h00 immediately, without waiting for a clock edge.
- RX path:
  - Device pushes 8'hA5 and 8'h3C; wait until interrupt=1, pulse int_ack, then two cpu_rd strobes.
  - Required:
    - interrupt rises 2 edges after the first push and falls on the ack edge.
    - cpu_data_in = A5, then 3C, one cycle after each strobe.
    - FSM returns to IDLE once rx_count=0.
- RX full:
  - Push 5 bytes 8'h01..8'h05 with no reads.
  - Required: dev_rx_ready=0 after the 4th, status[2]=1, rx_count=4, and later reads return 01..04.
- TX path:
  - cpu_wr 8'h11, 8'h22, 8'h33 with dev_tx_ready=0 for 3 cycles, then 1.
  - Required: dev_tx_data holds 11 while stalled, then 11, 22, 33 on successive ready cycles, then dev_tx_valid=0.
- Errors:
  - 5 cpu_wr while dev_tx_ready=0.
  - cpu_rd on an empty RX.
  - Required: status=3'b011, the 5th byte is absent from the TX output, and cpu_data_in is unchanged.
- Wrap-around:
  - Stream 10 RX bytes 8'h10..8'h19 with interleaved reads at equal rate (push and pop in the same cycle).
  - Required: data returned in order, rx_count never exceeds 1, status[1]=0.
